// File: rtl/draw_pkt_sched.sv
// Pen-sample packetiser: turns held pen samples into 3-byte draw frames and
// clear requests into 1-byte clear frames, with an idle gap after each frame.
module draw_pkt_sched #(
  parameter int GAP_CYCLES = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        pen_valid,
  input  logic [8:0]  pen_x,
  input  logic [7:0]  pen_y,
  input  logic [2:0]  pen_color,
  output logic        pen_ready,
  input  logic        clr_req,
  output logic [7:0]  pkt_out,
  output logic        pkt_valid,
  input  logic        pkt_ready,
  output logic        busy,
  output logic [15:0] frames_sent
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_XLO  = 3'd2;
  localparam logic [2:0] S_YB   = 3'd3;
  localparam logic [2:0] S_CLR  = 3'd4;
  localparam logic [2:0] S_GAP  = 3'd5;

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  logic [2:0]    state_q, state_d;
  logic          pen_pending_q, pen_pending_d;
  logic          clr_pending_q, clr_pending_d;
  logic          last_valid_q, last_valid_d;
  logic [8:0]    hold_x_q, hold_x_d;
  logic [7:0]    hold_y_q, hold_y_d;
  logic [2:0]    hold_c_q, hold_c_d;
  logic [8:0]    last_x_q, last_x_d;
  logic [7:0]    last_y_q, last_y_d;
  logic [2:0]    last_c_q, last_c_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [15:0]   frames_q, frames_d;

  logic       dup;
  logic [2:0] disp_state;
  logic       disp_drop;

  assign dup = last_valid_q &&
               ({hold_x_q, hold_y_q, hold_c_q} == {last_x_q, last_y_q, last_c_q});

  // Frame selection from idle: clear wins, duplicates are dropped silently
  always_comb begin
    disp_state = S_IDLE;
    disp_drop  = 1'b0;
    if (clr_pending_q) begin
      disp_state = S_CLR;
    end else if (pen_pending_q) begin
      if (dup) disp_drop = 1'b1;
      else     disp_state = S_HDR;
    end
  end

  // Next-state, holding register, pending flags and frame counter
  always_comb begin
    state_d       = state_q;
    pen_pending_d = pen_pending_q;
    clr_pending_d = clr_pending_q | clr_req;
    last_valid_d  = last_valid_q;
    hold_x_d      = hold_x_q;
    hold_y_d      = hold_y_q;
    hold_c_d      = hold_c_q;
    last_x_d      = last_x_q;
    last_y_d      = last_y_q;
    last_c_d      = last_c_q;
    gap_d         = gap_q;
    frames_d      = frames_q;

    if (pen_valid && !pen_pending_q) begin
      pen_pending_d = 1'b1;
      hold_x_d      = pen_x;
      hold_y_d      = pen_y;
      hold_c_d      = pen_color;
    end

    case (state_q)
      S_IDLE: begin
        state_d = disp_state;
        if (disp_drop) pen_pending_d = 1'b0;
      end
      S_HDR: if (pkt_ready) state_d = S_XLO;
      S_XLO: if (pkt_ready) state_d = S_YB;
      S_YB: begin
        if (pkt_ready) begin
          pen_pending_d = 1'b0;
          last_valid_d  = 1'b1;
          last_x_d      = hold_x_q;
          last_y_d      = hold_y_q;
          last_c_d      = hold_c_q;
          frames_d      = frames_q + 16'd1;
          gap_d         = GAP_LOAD;
          // With no gap, a pending clear starts on the very next cycle
          if (GAP_CYCLES == 0) state_d = clr_pending_q ? S_CLR : S_IDLE;
          else                 state_d = S_GAP;
        end
      end
      S_CLR: begin
        if (pkt_ready) begin
          clr_pending_d = 1'b0;
          last_valid_d  = 1'b0;
          frames_d      = frames_q + 16'd1;
          gap_d         = GAP_LOAD;
          // last_valid is being cleared, so a held sample can never be a duplicate here
          if (GAP_CYCLES == 0) state_d = pen_pending_q ? S_HDR : S_IDLE;
          else                 state_d = S_GAP;
        end
      end
      S_GAP: begin
        // Final gap cycle dispatches like IDLE so the gap is exactly GAP_CYCLES long
        if (gap_q == '0) begin
          state_d = disp_state;
          if (disp_drop) pen_pending_d = 1'b0;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= S_IDLE;
      pen_pending_q <= 1'b0;
      clr_pending_q <= 1'b0;
      last_valid_q  <= 1'b0;
      hold_x_q      <= '0;
      hold_y_q      <= '0;
      hold_c_q      <= '0;
      last_x_q      <= '0;
      last_y_q      <= '0;
      last_c_q      <= '0;
      gap_q         <= '0;
      frames_q      <= '0;
    end else begin
      state_q       <= state_d;
      pen_pending_q <= pen_pending_d;
      clr_pending_q <= clr_pending_d;
      last_valid_q  <= last_valid_d;
      hold_x_q      <= hold_x_d;
      hold_y_q      <= hold_y_d;
      hold_c_q      <= hold_c_d;
      last_x_q      <= last_x_d;
      last_y_q      <= last_y_d;
      last_c_q      <= last_c_d;
      gap_q         <= gap_d;
      frames_q      <= frames_d;
    end
  end

  // Byte encoding per transmit state
  always_comb begin
    pkt_out   = 8'h00;
    pkt_valid = 1'b1;
    case (state_q)
      S_HDR:   pkt_out = {1'b1, hold_c_q, 3'b000, hold_x_q[8]};
      S_XLO:   pkt_out = hold_x_q[7:0];
      S_YB:    pkt_out = hold_y_q;
      S_CLR:   pkt_out = 8'h01;
      default: pkt_valid = 1'b0;
    endcase
  end

  assign pen_ready   = !pen_pending_q;
  assign busy        = (state_q != S_IDLE) || pen_pending_q || clr_pending_q;
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_draw_pkt_sched.sv
// Bench for draw_pkt_sched: vector table, directed corner sequences and a
// randomized run against a byte-queue reference model.
module tb_draw_pkt_sched;

  localparam int GAPN = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        pv, clr, rdy;
  logic [8:0]  px;
  logic [7:0]  py;
  logic [2:0]  pc;
  logic        prdy_o, pvld, busy_o;
  logic [7:0]  pout;
  logic [15:0] frames;

  logic        z_pv, z_clr, z_rdy;
  logic [8:0]  z_px;
  logic [7:0]  z_py;
  logic [2:0]  z_pc;
  logic        z_prdy, z_pvld, z_busy;
  logic [7:0]  z_pout;
  logic [15:0] z_frames;

  draw_pkt_sched #(.GAP_CYCLES(GAPN)) u_dut (
    .clk_in(clk), .rst_in(rst), .pen_valid(pv), .pen_x(px), .pen_y(py),
    .pen_color(pc), .pen_ready(prdy_o), .clr_req(clr), .pkt_out(pout),
    .pkt_valid(pvld), .pkt_ready(rdy), .busy(busy_o), .frames_sent(frames)
  );

  draw_pkt_sched #(.GAP_CYCLES(0)) u_dut0 (
    .clk_in(clk), .rst_in(rst), .pen_valid(z_pv), .pen_x(z_px), .pen_y(z_py),
    .pen_color(z_pc), .pen_ready(z_prdy), .clr_req(z_clr), .pkt_out(z_pout),
    .pkt_valid(z_pvld), .pkt_ready(z_rdy), .busy(z_busy), .frames_sent(z_frames)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] hdr(input logic [2:0] c, input logic [8:0] x);
    return {1'b1, c, 3'b000, x[8]};
  endfunction

  typedef struct {
    logic        pv;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [2:0]  c;
    logic        rdy;
    logic        ev;
    logic [7:0]  eo;
    logic        epr;
    logic        eb;
    logic [15:0] ef;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic pv_, input logic [8:0] x_, input logic [7:0] y_,
                              input logic [2:0] c_, input logic rdy_, input logic ev_,
                              input logic [7:0] eo_, input logic epr_, input logic eb_,
                              input logic [15:0] ef_);
    vec_t v;
    v.pv = pv_; v.x = x_; v.y = y_; v.c = c_; v.rdy = rdy_;
    v.ev = ev_; v.eo = eo_; v.epr = epr_; v.eb = eb_; v.ef = ef_;
    tbl.push_back(v);
  endfunction

  // Checks {valid,byte} over successive cycles; one-shot inputs drop after the first edge
  task automatic expect_stream(input string tag, input logic [8:0] e[$]);
    for (int k = 0; k < e.size(); k++) begin
      @(negedge clk);
      pv  = 1'b0;
      clr = 1'b0;
      check($sformatf("%s[%0d]", tag, k), 32'({pvld, pout}), 32'(e[k]));
    end
  endtask

  task automatic send_frame(input logic [8:0] x, input logic [7:0] y, input logic [2:0] c,
                            input bit sent, input string tag);
    logic [8:0] e[$];
    pv = 1'b1; px = x; py = y; pc = c; rdy = 1'b1;
    if (sent) e = '{9'h000, {1'b1, hdr(c, x)}, {1'b1, x[7:0]}, {1'b1, y}, 9'h000};
    else      e = '{9'h000, 9'h000, 9'h000};
    expect_stream(tag, e);
    check({tag, ".pen_ready"}, 32'(prdy_o), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (busy_o === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, ".idle_timeout"}, 32'(ok), 32'd1);
  endtask

  // Reference model: pending flags, a queue of bytes still to send and a gap count
  logic [7:0]  mq[$];
  bit          m_isclr, m_pen, m_clr, m_lastv;
  logic [19:0] m_hold, m_last;
  int          m_gap;
  logic [15:0] m_frames;

  task automatic model_reset();
    mq.delete();
    m_isclr = 0; m_pen = 0; m_clr = 0; m_lastv = 0;
    m_hold = '0; m_last = '0; m_gap = 0; m_frames = '0;
  endtask

  task automatic model_step(input logic i_pv, input logic [19:0] i_s,
                            input logic i_clr, input logic i_rdy);
    bit pen_pre, disp, cdone;
    pen_pre = m_pen;
    disp    = 0;
    cdone   = 0;
    if (mq.size() > 0) begin
      if (i_rdy) begin
        void'(mq.pop_front());
        if (mq.size() == 0) begin
          m_frames = m_frames + 16'd1;
          if (m_isclr) begin
            m_clr = 0; m_lastv = 0; cdone = 1;
          end else begin
            m_pen = 0; m_last = m_hold; m_lastv = 1;
          end
          m_gap = GAPN;
          disp  = (GAPN == 0);
        end
      end
    end else if (m_gap > 0) begin
      m_gap = m_gap - 1;
      disp  = (m_gap == 0);
    end else begin
      disp = 1;
    end
    if (disp) begin
      if (m_clr) begin
        mq.push_back(8'h01);
        m_isclr = 1;
      end else if (m_pen) begin
        if (m_lastv && m_hold == m_last) begin
          m_pen = 0;
        end else begin
          mq.push_back(hdr(m_hold[2:0], m_hold[19:11]));
          mq.push_back(m_hold[18:11]);
          mq.push_back(m_hold[10:3]);
          m_isclr = 0;
        end
      end
    end
    if (i_clr && !cdone) m_clr = 1;
    if (i_pv && !pen_pre) begin
      m_pen  = 1;
      m_hold = i_s;
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [8:0]  e[$];
    logic [8:0]  sx[4];
    logic [7:0]  sy[4];
    logic [2:0]  sc[4];
    int          nb, n01, idx;
    logic        ev;
    logic [7:0]  eo;

    rst = 1'b1;
    pv = 0; clr = 0; rdy = 1; px = '0; py = '0; pc = '0;
    z_pv = 0; z_clr = 0; z_rdy = 1; z_px = '0; z_py = '0; z_pc = '0;
    repeat (2) @(negedge clk);
    check("rst.pkt_valid", 32'(pvld), 32'd0);
    check("rst.pkt_out", 32'(pout), 32'h00);
    check("rst.pen_ready", 32'(prdy_o), 32'd1);
    check("rst.busy", 32'(busy_o), 32'd0);
    check("rst.frames", 32'(frames), 32'd0);
    rst = 1'b0;

    // Draw, duplicate suppression, colour change, back-pressure in XLO
    add(1, 9'h13F, 8'hEF, 3'd5, 1, 0, 8'h00, 0, 1, 0);
    add(0, 0, 0, 0, 1, 1, 8'hD1, 0, 1, 0);
    add(0, 0, 0, 0, 1, 1, 8'h3F, 0, 1, 0);
    add(0, 0, 0, 0, 1, 1, 8'hEF, 0, 1, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 1, 0, 8'h00, 1, 1, 1);
    add(0, 0, 0, 0, 1, 0, 8'h00, 1, 0, 1);
    add(1, 9'h13F, 8'hEF, 3'd5, 1, 0, 8'h00, 0, 1, 1);
    add(0, 0, 0, 0, 1, 0, 8'h00, 1, 0, 1);
    add(1, 9'h13F, 8'hEF, 3'd6, 1, 0, 8'h00, 0, 1, 1);
    add(0, 0, 0, 0, 1, 1, 8'hE1, 0, 1, 1);
    add(0, 0, 0, 0, 1, 1, 8'h3F, 0, 1, 1);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0, 1, 8'h3F, 0, 1, 1);
    add(0, 0, 0, 0, 1, 1, 8'hEF, 0, 1, 1);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 1, 0, 8'h00, 1, 1, 2);
    add(0, 0, 0, 0, 1, 0, 8'h00, 1, 0, 2);

    for (int i = 0; i < tbl.size(); i++) begin
      pv = tbl[i].pv; px = tbl[i].x; py = tbl[i].y; pc = tbl[i].c; rdy = tbl[i].rdy;
      @(negedge clk);
      check($sformatf("tbl%0d.valid", i), 32'(pvld), 32'(tbl[i].ev));
      check($sformatf("tbl%0d.out", i), 32'(pout), 32'(tbl[i].eo));
      check($sformatf("tbl%0d.pen_ready", i), 32'(prdy_o), 32'(tbl[i].epr));
      check($sformatf("tbl%0d.busy", i), 32'(busy_o), 32'(tbl[i].eb));
      check($sformatf("tbl%0d.frames", i), 32'(frames), 32'(tbl[i].ef));
    end
    pv = 0; rdy = 1;

    // Clear and pen in the same cycle: clear first, gap, then the draw frame
    pv = 1; px = 9'h13F; py = 8'hEF; pc = 3'd5; clr = 1;
    e = '{9'h000, 9'h101, 9'h000, 9'h000, 9'h000, 9'h000, 9'h1D1, 9'h13F, 9'h1EF, 9'h000};
    expect_stream("clr_then_draw", e);
    check("clr_then_draw.frames", 32'(frames), 32'd4);
    wait_idle("clr_then_draw");

    // Three clear pulses while one is pending merge into one clear frame
    rdy = 0;
    for (int i = 0; i < 3; i++) begin
      clr = 1; @(negedge clk);
      clr = 0; @(negedge clk);
    end
    rdy = 1;
    nb = 0; n01 = 0;
    repeat (15) begin
      if (pvld && rdy) begin
        nb++;
        if (pout == 8'h01) n01++;
      end
      @(negedge clk);
    end
    check("merge.bytes", 32'(nb), 32'd1);
    check("merge.clr_bytes", 32'(n01), 32'd1);
    check("merge.frames", 32'(frames), 32'd5);
    wait_idle("merge");

    // Reset mid-frame clears the duplicate filter and abandons the frame
    send_frame(9'h13F, 8'hEF, 3'd5, 1, "pre_rst");
    wait_idle("pre_rst");
    send_frame(9'h13F, 8'hEF, 3'd5, 0, "dup");
    pv = 1; px = 9'h1A5; py = 8'h00; pc = 3'd0;
    @(negedge clk); pv = 0;
    @(negedge clk);
    check("t.hdr", 32'({pvld, pout}), 32'h181);
    @(negedge clk);
    check("t.xlo", 32'({pvld, pout}), 32'h1A5);
    #2 rst = 1;
    #1;
    check("midrst.pkt_valid", 32'(pvld), 32'd0);
    check("midrst.pkt_out", 32'(pout), 32'h00);
    check("midrst.pen_ready", 32'(prdy_o), 32'd1);
    check("midrst.busy", 32'(busy_o), 32'd0);
    check("midrst.frames", 32'(frames), 32'd0);
    @(negedge clk);
    rst = 0;
    send_frame(9'h13F, 8'hEF, 3'd5, 1, "post_rst");
    check("post_rst.frames", 32'(frames), 32'd1);
    wait_idle("post_rst");

    // No-gap instance: counter wrap and back-to-back clear then draw
    force u_dut0.frames_q = 16'hFFFF;
    @(negedge clk);
    release u_dut0.frames_q;
    check("z.frames_forced", 32'(z_frames), 32'hFFFF);
    z_pv = 1; z_px = 9'h13F; z_py = 8'hEF; z_pc = 3'd5; z_clr = 1;
    e = '{9'h000, 9'h101, 9'h1D1, 9'h13F, 9'h1EF, 9'h000};
    for (int k = 0; k < e.size(); k++) begin
      @(negedge clk);
      z_pv = 0; z_clr = 0;
      check($sformatf("z.stream[%0d]", k), 32'({z_pvld, z_pout}), 32'(e[k]));
      if (k == 2) check("z.frames_wrap", 32'(z_frames), 32'd0);
    end
    check("z.frames_after", 32'(z_frames), 32'd1);

    // Randomized run against the reference model
    sx = '{9'h13F, 9'h000, 9'h0A0, 9'h101};
    sy = '{8'hEF, 8'h00, 8'h55, 8'h80};
    sc = '{3'd5, 3'd0, 3'd7, 3'd2};
    rst = 1;
    @(negedge clk);
    rst = 0;
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      ev = (mq.size() > 0);
      eo = ev ? mq[0] : 8'h00;
      check($sformatf("rand%0d", cyc),
            32'({pvld, pout, prdy_o, busy_o, frames}),
            32'({ev, eo, !m_pen, ev || m_gap > 0 || m_pen || m_clr, m_frames}));
      idx = $urandom_range(0, 3);
      pv  = 1'($urandom_range(0, 1));
      px  = sx[idx];
      py  = sy[idx];
      pc  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : sc[idx];
      clr = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      model_step(pv, {px, py, pc}, clr, rdy);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/draw_pkt_sched.md
DRAW_PKT_SCHED -- requirements
Module: draw_pkt_sched

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 4, idle cycles inserted after every frame (0 = no gap).
REQ-002 SHALL have ports, clock and reset first:
- clk_in  input  1  system clock; all state changes on its rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- pen_valid  input  1  pen sample offered.
- pen_x  input  9  pen x coordinate, 0..319.
- pen_y  input  8  pen y coordinate, 0..239.
- pen_color  input  3  pen colour index.
- pen_ready  output  1  pen holding register is empty.
- clr_req  input  1  one-cycle clear-canvas request pulse.
- pkt_out  output  8  byte to the link layer.
- pkt_valid  output  1  pkt_out is valid.
- pkt_ready  input  1  link layer accepts the byte.
- busy  output  1  state is not IDLE, or a request is pending.
- frames_sent  output  16  count of completed frames, draw and clear.

Function
REQ-003 SHALL accept a pen sample when pen_valid && pen_ready, latching x/y/color into a one-entry holding register and setting pen_pending.
REQ-004 SHALL drive pen_ready = !pen_pending.
REQ-005 SHALL set clr_pending on any clr_req; repeated pulses while clr_pending is set merge into one clear frame.
REQ-006 SHALL transfer a byte only in a cycle with pkt_valid && pkt_ready; pkt_out SHALL hold stable while pkt_valid=1 and pkt_ready=0.
REQ-007 SHALL use the states IDLE, HDR, XLO, YB, CLR, GAP.
REQ-008 In IDLE, clr_pending SHALL have priority: next state CLR.
REQ-009 In IDLE with only pen_pending set:
- Duplicate sample (last_valid && held {x,y,color} == last sent): clear pen_pending and stay in IDLE; no bytes are output.
- Otherwise: next state HDR.
REQ-010 Byte encodings:
- HDR: pkt_out = {1'b1, color[2:0], 3'b000, x[8]}.
- XLO: pkt_out = x[7:0].
- YB: pkt_out = y[7:0].
- CLR: pkt_out = 8'h01.
- pkt_valid=1 in these four states only.
REQ-011 Transitions on handshake:
- HDR to XLO, XLO to YB.
- YB to GAP, clearing pen_pending and recording last = held sample with last_valid=1.
- CLR to GAP, clearing clr_pending and last_valid.
- When GAP_CYCLES=0, SHALL go directly to IDLE instead of GAP.
REQ-012 GAP SHALL hold pkt_valid=0 for exactly GAP_CYCLES cycles, then go to IDLE.
REQ-013 frames_sent SHALL increment by 1 on the final-byte handshake of each frame (YB or CLR) and wrap from 16'hFFFF to 0.
REQ-014 Latency:
- Sample accepted at edge E0: pkt_valid=1 for HDR in the cycle after edge E1.
- A suppressed duplicate frees pen_ready after edge E1.
REQ-015 clr_req arriving mid-frame SHALL NOT abort the frame; the clear is sent after the frame and its gap.
REQ-016 clr_req and pen acceptance in the same cycle SHALL latch both; the clear frame goes out first, then the draw frame.
REQ-017 The holding register SHALL NOT change while a draw frame is in HDR/XLO/YB, because pen_ready=0 in those states.
REQ-018 busy SHALL equal (state != IDLE) || pen_pending || clr_pending.

Reset
REQ-019 On rst_in=1, asynchronously and at any point mid-frame, the block SHALL set:
- state=IDLE, pen_pending=0, clr_pending=0, last_valid=0.
- pkt_valid=0, pkt_out=8'h00, pen_ready=1, busy=0, frames_sent=0.
- GAP counter=0.
- Any partially sent frame is abandoned and not resumed.
REQ-020 After rst_in falls, the first pen sample SHALL always be sent, because the duplicate filter is cleared.

Verification
REQ-021 Pen (x=9'h13F, y=8'hEF, color=3'd5), pkt_ready=1 -> bytes 8'hD1, 8'h3F, 8'hEF on consecutive cycles, then pkt_valid=0 for 4 cycles; frames_sent=1.
REQ-022 The same sample re-sent -> no bytes; pen_ready returns after 2 cycles; frames_sent unchanged. A different colour -> full frame sent.
REQ-023 pkt_ready=0 for 5 cycles during XLO -> pkt_out stays 8'h3F with pkt_valid=1; the frame resumes with YB on ready.
REQ-024 clr_req and pen_valid in the same cycle -> 8'h01, 4-cycle gap, then the 3-byte draw frame; three clr_req pulses while pending -> a single 8'h01.
REQ-025 rst_in asserted during XLO -> pkt_valid=0 immediately and all outputs at reset values; the next identical sample is resent in full.
REQ-026 Force frames_sent=16'hFFFF, send one clear -> frames_sent=0; with GAP_CYCLES=0, back-to-back frames show no idle cycle.
